// File: rtl/sint_out_arb_if.sv
// sint_out_arb_if: three valid/stall requester streams in, one merged valid/stall stream out
//   tf/ssf/ssh_ds_valid, *_ray_out : requester beats toward the arbiter
//   tf/ssf/ssh_ds_stall            : per-requester hold
//   out_valid, out_data, out_src   : merged stream with source tag
//   ds_stall                       : downstream back-pressure
interface sint_out_arb_if #(parameter int W = 64);
  logic         tf_ds_valid;
  logic [W-1:0] tf_ray_out;
  logic         tf_ds_stall;
  logic         ssf_ds_valid;
  logic [W-1:0] ssf_ray_out;
  logic         ssf_ds_stall;
  logic         ssh_ds_valid;
  logic [W-1:0] ssh_ray_out;
  logic         ssh_ds_stall;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         ds_stall;
  modport slave (
    input  tf_ds_valid, tf_ray_out, ssf_ds_valid, ssf_ray_out, ssh_ds_valid, ssh_ray_out, ds_stall,
    output tf_ds_stall, ssf_ds_stall, ssh_ds_stall, out_valid, out_data, out_src
  );
  modport master (
    output tf_ds_valid, tf_ray_out, ssf_ds_valid, ssf_ray_out, ssh_ds_valid, ssh_ray_out, ds_stall,
    input  tf_ds_stall, ssf_ds_stall, ssh_ds_stall, out_valid, out_data, out_src
  );
endinterface

// File: rtl/sint_out_arb.sv
// sint_out_arb: round-robin merge of tf/ssf/ssh streams through a 2-entry skid buffer with per-source beat counters
//   clk, rst_b : clock, async active-low reset
//   bus        : requester and merged output streams (sint_out_arb_if.slave)
//   cnt_clr    : synchronous clear of the beat counters
//   tf/ssf/ssh_cnt : beats accepted per source since reset/clear
module sint_out_arb #(
  parameter int W     = 64,
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst_b,
  sint_out_arb_if.slave    bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] tf_cnt,
  output logic [CNT_W-1:0] ssf_cnt,
  output logic [CNT_W-1:0] ssh_cnt
);
  typedef enum logic [1:0] {RR_TF = 2'd0, RR_SSF = 2'd1, RR_SSH = 2'd2} rr_t;
  rr_t          rr_q, rr_d;
  logic [2:0]   v;
  logic [1:0]   c0, c1, c2, gnt, count, tail_src;
  logic [W-1:0] in_data, tail_data;
  logic         push, pop;
  assign v = {bus.ssh_ds_valid, bus.ssf_ds_valid, bus.tf_ds_valid};
  // c0..c2 is the search order starting at rr_q; c2 wins only when it is the sole choice left
  always_comb begin
    c0      = rr_q;
    c1      = (rr_q == RR_SSH) ? 2'd0 : c0 + 2'd1;
    c2      = (rr_q == RR_TF) ? 2'd2 : c0 - 2'd1;
    gnt     = v[c0] ? c0 : v[c1] ? c1 : c2;
    in_data = (gnt == 2'd0) ? bus.tf_ray_out : (gnt == 2'd1) ? bus.ssf_ray_out : bus.ssh_ray_out;
    rr_d    = push ? rr_t'((gnt == 2'd2) ? 2'd0 : gnt + 2'd1) : rr_q;
  end
  // rst_b gates push so every stall reads 1 while reset is held, whatever the valids do
  assign push             = rst_b & (|v) & (count != 2'd2);
  assign pop              = bus.out_valid & ~bus.ds_stall;
  assign bus.out_valid    = count != 2'd0;
  assign bus.tf_ds_stall  = ~(push & (gnt == 2'd0));
  assign bus.ssf_ds_stall = ~(push & (gnt == 2'd1));
  assign bus.ssh_ds_stall = ~(push & (gnt == 2'd2));
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) rr_q <= RR_TF;
    else rr_q <= rr_d;
  // out_data/out_src are the head entry itself, so they keep their last value once the buffer drains
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count        <= 2'd0;
      bus.out_data <= '0;
      bus.out_src  <= 2'd0;
      tail_data    <= '0;
      tail_src     <= 2'd0;
    end else begin
      if (push & ~pop) count <= count + 2'd1;
      else if (pop & ~push) count <= count - 2'd1;
      if (push & ((count == 2'd0) | pop)) {bus.out_src, bus.out_data} <= {gnt, in_data};
      else if (pop & (count == 2'd2)) {bus.out_src, bus.out_data} <= {tail_src, tail_data};
      if (push & ~pop & (count == 2'd1)) {tail_src, tail_data} <= {gnt, in_data};
    end
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tf_cnt  <= '0;
      ssf_cnt <= '0;
      ssh_cnt <= '0;
    end else if (cnt_clr) begin
      tf_cnt  <= '0;
      ssf_cnt <= '0;
      ssh_cnt <= '0;
    end else begin
      tf_cnt  <= tf_cnt + CNT_W'(push & (gnt == 2'd0));
      ssf_cnt <= ssf_cnt + CNT_W'(push & (gnt == 2'd1));
      ssh_cnt <= ssh_cnt + CNT_W'(push & (gnt == 2'd2));
    end
  end
endmodule

// File: tb/tb_sint_out_arb.sv
// tb_sint_out_arb: directed checks of arbitration order, skid buffering, counters and reset
module tb_sint_out_arb;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [18:0] tf_cnt, ssf_cnt, ssh_cnt;
  int          checks = 0;
  int          errors = 0;
  sint_out_arb_if #(.W(64)) bus ();
  sint_out_arb #(.W(64), .CNT_W(19)) dut (
    .clk(clk), .rst_b(rst_b), .bus(bus), .cnt_clr(cnt_clr),
    .tf_cnt(tf_cnt), .ssf_cnt(ssf_cnt), .ssh_cnt(ssh_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_v(input logic t, input logic f, input logic h);
    bus.tf_ds_valid  = t;
    bus.ssf_ds_valid = f;
    bus.ssh_ds_valid = h;
  endtask
  initial begin
    set_v(1, 1, 1);
    bus.tf_ray_out  = 64'h100;
    bus.ssf_ray_out = 64'h200;
    bus.ssh_ray_out = 64'h300;
    bus.ds_stall    = 1'b0;
    tick();
    tick();
    chk("rst_tf_stall", bus.tf_ds_stall, 1);
    chk("rst_ssf_stall", bus.ssf_ds_stall, 1);
    chk("rst_ssh_stall", bus.ssh_ds_stall, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_src", bus.out_src, 0);
    chk("rst_cnts", {tf_cnt, ssf_cnt, ssh_cnt}, 0);
    rst_b = 1'b1;
    #1;
    chk("rr_tf_first", bus.tf_ds_stall, 0);
    chk("rr_ssf_held", bus.ssf_ds_stall, 1);
    chk("rr_ssh_held", bus.ssh_ds_stall, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_valid", bus.out_valid, 1);
      chk("rr_src", bus.out_src, 64'(i % 3));
      chk("rr_data", bus.out_data, 64'((i % 3 + 1) * 256));
    end
    chk("rr_tf_cnt", tf_cnt, 2);
    chk("rr_ssf_cnt", ssf_cnt, 2);
    chk("rr_ssh_cnt", ssh_cnt, 2);
    set_v(0, 0, 0);
    tick();
    chk("drain_valid", bus.out_valid, 0);
    chk("hold_data", bus.out_data, 64'h300);
    chk("hold_src", bus.out_src, 2);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnts", {tf_cnt, ssf_cnt, ssh_cnt}, 0);
    set_v(0, 0, 1);
    bus.ssh_ray_out = 64'hA5;
    tick();
    bus.ssh_ray_out = 64'h5A;
    chk("ssh_a5_data", bus.out_data, 64'hA5);
    chk("ssh_a5_src", bus.out_src, 2);
    tick();
    set_v(0, 0, 0);
    chk("ssh_5a_data", bus.out_data, 64'h5A);
    chk("ssh_5a_src", bus.out_src, 2);
    tick();
    chk("ssh_cnt", ssh_cnt, 2);
    chk("ssh_only_other_cnts", {tf_cnt, ssf_cnt}, 0);
    chk("ssh_drained", bus.out_valid, 0);
    set_v(1, 0, 0);
    bus.tf_ray_out = 64'h11;
    bus.ds_stall   = 1'b1;
    tick();
    bus.tf_ray_out = 64'h22;
    chk("skid_one_stall", bus.tf_ds_stall, 0);
    tick();
    bus.tf_ray_out = 64'h33;
    chk("skid_full_stall", bus.tf_ds_stall, 1);
    chk("skid_head", bus.out_data, 64'h11);
    tick();
    chk("skid_still_full", bus.tf_ds_stall, 1);
    chk("skid_still_head", bus.out_data, 64'h11);
    chk("skid_tf_cnt", tf_cnt, 2);
    bus.ds_stall = 1'b0;
    tick();
    chk("skid_second", bus.out_data, 64'h22);
    chk("skid_resume", bus.tf_ds_stall, 0);
    tick();
    chk("skid_third", bus.out_data, 64'h33);
    chk("skid_tf_cnt3", tf_cnt, 3);
    set_v(0, 0, 0);
    tick();
    chk("skid_drained", bus.out_valid, 0);
    set_v(0, 1, 0);
    bus.ssf_ray_out = 64'h55;
    tick();
    chk("pp_head", bus.out_data, 64'h55);
    chk("pp_head_src", bus.out_src, 1);
    set_v(1, 0, 0);
    bus.tf_ray_out = 64'h66;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    set_v(0, 0, 0);
    chk("pp_count1", bus.out_valid, 1);
    chk("pp_data", bus.out_data, 64'h66);
    chk("pp_src", bus.out_src, 0);
    chk("clr_beats_accept", tf_cnt, 0);
    chk("clr_ssf", ssf_cnt, 0);
    tick();
    chk("pp_drained", bus.out_valid, 0);
    set_v(0, 1, 1);
    bus.ssf_ray_out = 64'h77;
    bus.ssh_ray_out = 64'h88;
    bus.ds_stall    = 1'b1;
    tick();
    tick();
    chk("mid_full_head", bus.out_data, 64'h77);
    chk("mid_full_valid", bus.out_valid, 1);
    set_v(1, 1, 1);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_stalls", {bus.tf_ds_stall, bus.ssf_ds_stall, bus.ssh_ds_stall}, 3'b111);
    tick();
    rst_b = 1'b1;
    bus.ds_stall = 1'b0;
    #1;
    chk("restart_tf", bus.tf_ds_stall, 0);
    chk("restart_ssf", bus.ssf_ds_stall, 1);
    tick();
    chk("restart_src0", bus.out_src, 0);
    chk("restart_data0", bus.out_data, 64'h66);
    tick();
    chk("restart_src1", bus.out_src, 1);
    chk("restart_data1", bus.out_data, 64'h77);
    chk("restart_tf_cnt", tf_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
